// File: rtl/video_pattern_pkg.sv
`default_nettype none
// ============================================================================
// Module   : video_pattern_pkg
// Purpose  : Shared types and constants for the video pattern source:
//            pattern-select enum, FSM state enum, 8-entry colour-bar table,
//            beat geometry and the 64-bit pixel packing helper.
// Revision : 1.0 - initial release
// ============================================================================
package video_pattern_pkg;

  localparam int PIXELS_PER_BEAT = 4;
  localparam int PIXEL_PACK_W    = 64;
  localparam int COLOR_W         = 24;

  typedef enum logic [1:0] {
    PAT_BARS     = 2'd0,
    PAT_GRADIENT = 2'd1,
    PAT_CHECKER  = 2'd2,
    PAT_SOLID    = 2'd3
  } pattern_e;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  // {R,G,B}: white, yellow, cyan, green, magenta, red, blue, black
  localparam logic [COLOR_W-1:0] BAR_COLORS [8] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

  // Each 8-bit channel sits in the upper byte of a 16-bit lane; [63:48] is zero.
  function automatic logic [PIXEL_PACK_W-1:0] pack_pixel(input logic [COLOR_W-1:0] rgb);
    return {16'h0000, rgb[23:16], 8'h00, rgb[15:8], 8'h00, rgb[7:0], 8'h00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/video_pattern_if.sv
`default_nettype none
// ============================================================================
// Module   : video_pattern_if
// Purpose  : Pixel-beat stream interface (4 pixels per beat, valid/ready).
// Ports    : valid, frame_done, bits_0..bits_3 (master->slave), ready (slave->master)
// Revision : 1.0 - initial release
// ============================================================================
interface video_pattern_if;
  import video_pattern_pkg::*;

  logic                    valid;
  logic                    ready;
  logic                    frame_done;
  logic [PIXEL_PACK_W-1:0] bits_0;
  logic [PIXEL_PACK_W-1:0] bits_1;
  logic [PIXEL_PACK_W-1:0] bits_2;
  logic [PIXEL_PACK_W-1:0] bits_3;

  modport master (
    output valid, frame_done, bits_0, bits_1, bits_2, bits_3,
    input  ready
  );

  modport slave (
    input  valid, frame_done, bits_0, bits_1, bits_2, bits_3,
    output ready
  );

endinterface
`default_nettype wire

// File: rtl/video_pattern_pixel.sv
`default_nettype none
// ============================================================================
// Module   : video_pattern_pixel
// Purpose  : Combinational colour function for one pixel of the beat.
// Ports    : pattern, px (evaluation x), py, frame_lsb, bar_step (width/8),
//            solid_color, in_range -> pixel (packed 64-bit, zero if !in_range)
// Revision : 1.0 - initial release
// ============================================================================
module video_pattern_pixel
  import video_pattern_pkg::*;
#(
  parameter int CHECKER_SHIFT = 5
) (
  input  pattern_e                pattern,
  input  logic [15:0]             px,
  input  logic [15:0]             py,
  input  logic [7:0]              frame_lsb,
  input  logic [15:0]             bar_step,
  input  logic [COLOR_W-1:0]      solid_color,
  input  logic                    in_range,
  output logic [PIXEL_PACK_W-1:0] pixel
);

  logic [2:0]         w_bar_idx;
  logic [COLOR_W-1:0] w_rgb;
  logic               unused_py_bits;

  assign unused_py_bits = &{1'b0, py[15:8]};

  // Bar index = number of thresholds k*step (k=1..7) not above px.
  // 19-bit products keep 7*step exact for any 16-bit width.
  always_comb begin
    w_bar_idx = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if ((19'(k) * {3'b000, bar_step}) <= {3'b000, px}) begin
        w_bar_idx = w_bar_idx + 3'd1;
      end
    end
  end

  always_comb begin
    w_rgb = '0;
    case (pattern)
      PAT_BARS:     w_rgb = BAR_COLORS[w_bar_idx];
      PAT_GRADIENT: w_rgb = {px[7:0], py[7:0], frame_lsb};
      PAT_CHECKER:  w_rgb = (px[CHECKER_SHIFT] ^ py[CHECKER_SHIFT]) ? 24'hFFFFFF : 24'h000000;
      PAT_SOLID:    w_rgb = solid_color;
      default:      w_rgb = '0;
    endcase
  end

  assign pixel = in_range ? pack_pixel(w_rgb) : '0;

endmodule
`default_nettype wire

// File: rtl/video_pattern_source.sv
`default_nettype none
// ============================================================================
// Module   : video_pattern_source
// Purpose  : Test-pattern generator emitting 4 pixels per beat over a
//            valid/ready stream (bars, gradient, checkerboard, solid).
// Ports    : clock, reset (sync, active-high)
//            video_width/video_height/pattern_select/solid_color: latched on
//            an accepted start_frame
//            start_frame: request a new frame (restarts an active one)
//            vid (video_pattern_if.master): valid, ready, bits_0..3, frame_done
// Options  : VIDEO_PATTERN_MOTION_EN - offset pattern x by frame_count so bars
//            and checker scroll one pixel per frame.
// Revision : 1.0 - initial release
// ============================================================================
module video_pattern_source
  import video_pattern_pkg::*;
#(
  parameter int CHECKER_SHIFT = 5,
  parameter int BAR_COUNT     = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [15:0]        video_width,
  input  logic [15:0]        video_height,
  input  logic [1:0]         pattern_select,
  input  logic [COLOR_W-1:0] solid_color,
  input  logic               start_frame,
  video_pattern_if.master    vid
);

  localparam int BAR_SHIFT = $clog2(BAR_COUNT);

  state_e             r_state;
  state_e             w_state_next;
  logic [15:0]        r_x;
  logic [15:0]        r_y;
  logic [15:0]        r_width;
  logic [15:0]        r_height;
  logic [15:0]        r_frame_count;
  pattern_e           r_pattern;
  logic [COLOR_W-1:0] r_solid;

  logic               w_active;
  logic               w_xfer;
  logic               w_start_ok;
  logic               w_last_x;
  logic               w_last_y;
  logic               w_last_beat;
  logic               w_frame_done;
  logic [15:0]        w_offset;
  logic [15:0]        w_bar_step;
  logic [PIXEL_PACK_W-1:0] w_pix [PIXELS_PER_BEAT];

  assign w_active    = (r_state == ST_ACTIVE);
  assign w_xfer      = w_active && vid.ready;
  assign w_start_ok  = start_frame && (video_width != 16'd0) && (video_height != 16'd0);
  // 17-bit compares so x+4 / y+1 cannot wrap near 65535
  assign w_last_x    = ({1'b0, r_x} + 17'd4) >= {1'b0, r_width};
  assign w_last_y    = ({1'b0, r_y} + 17'd1) >= {1'b0, r_height};
  assign w_last_beat = w_last_x && w_last_y;
  assign w_bar_step  = r_width >> BAR_SHIFT;

`ifdef VIDEO_PATTERN_MOTION_EN
  assign w_offset = r_frame_count;
`else
  assign w_offset = 16'd0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Any start_frame while active abandons the frame without frame_done;
  // it restarts if the new geometry is non-zero, otherwise drops to idle.
  always_comb begin
    w_state_next = r_state;
    w_frame_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start_ok) w_state_next = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (start_frame) begin
          w_state_next = w_start_ok ? ST_ACTIVE : ST_IDLE;
        end else if (w_xfer && w_last_beat) begin
          w_state_next = ST_IDLE;
          w_frame_done = 1'b1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_x           <= '0;
      r_y           <= '0;
      r_width       <= '0;
      r_height      <= '0;
      r_frame_count <= '0;
      r_pattern     <= PAT_BARS;
      r_solid       <= '0;
    end else begin
      if (w_start_ok) begin
        r_x       <= '0;
        r_y       <= '0;
        r_width   <= video_width;
        r_height  <= video_height;
        r_pattern <= pattern_e'(pattern_select);
        r_solid   <= solid_color;
      end else if (w_xfer && !start_frame) begin
        if (w_last_x) begin
          r_x <= '0;
          r_y <= r_y + 16'd1;
        end else begin
          r_x <= r_x + 16'd4;
        end
      end
      if (w_frame_done) begin
        r_frame_count <= r_frame_count + 16'd1;
      end
    end
  end

  generate
    for (genvar i = 0; i < PIXELS_PER_BEAT; i++) begin : g_pixel
      logic [15:0] w_eval_x;
      logic        w_in_range;

      assign w_eval_x   = r_x + 16'(i) + w_offset;
      // Pixels past the line end (width not a multiple of 4) are black.
      assign w_in_range = w_active && (({1'b0, r_x} + 17'(i)) < {1'b0, r_width});

      video_pattern_pixel #(
        .CHECKER_SHIFT (CHECKER_SHIFT)
      ) u_pixel (
        .pattern     (r_pattern),
        .px          (w_eval_x),
        .py          (r_y),
        .frame_lsb   (r_frame_count[7:0]),
        .bar_step    (w_bar_step),
        .solid_color (r_solid),
        .in_range    (w_in_range),
        .pixel       (w_pix[i])
      );
    end
  endgenerate

  assign vid.valid      = w_active;
  assign vid.frame_done = w_frame_done;
  assign vid.bits_0     = w_pix[0];
  assign vid.bits_1     = w_pix[1];
  assign vid.bits_2     = w_pix[2];
  assign vid.bits_3     = w_pix[3];

endmodule
`default_nettype wire

// File: tb/tb_video_pattern_source.sv
`default_nettype none
// ============================================================================
// Module   : tb_video_pattern_source
// Purpose  : Self-checking bench for video_pattern_source. Expected beats are
//            generated from a reference pattern model into a queue when a
//            frame is started and popped as the DUT transfers beats.
// Options  : VIDEO_PATTERN_MOTION_EN - enables scrolling expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_video_pattern_source;
  import video_pattern_pkg::*;

  typedef struct {
    logic [255:0] bits;
    logic         last;
  } beat_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] width = 16'd0;
  logic [15:0] height = 16'd0;
  logic [1:0]  pattern_sel = 2'd0;
  logic [23:0] solid = 24'd0;
  logic        start_frame = 1'b0;

  logic         obs_valid;
  logic         obs_fd;
  logic [255:0] obs_bits;

  beat_t sb[$];
  int    exp_fc = 0;
  int    n_tests = 0;
  int    n_fail = 0;

  always #5 clock = ~clock;

  video_pattern_if vif ();

  video_pattern_source #(
    .CHECKER_SHIFT (5),
    .BAR_COUNT     (8)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .video_width    (width),
    .video_height   (height),
    .pattern_select (pattern_sel),
    .solid_color    (solid),
    .start_frame    (start_frame),
    .vid            (vif)
  );

  // ---------------- reference model ----------------
  function automatic logic [23:0] bar_color(input int idx);
    case (idx)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic logic [63:0] m_pix(input logic [1:0] pat, input int px, input int py,
                                        input int w, input logic [23:0] sc, input int fc);
    logic [15:0] ex;
    logic [15:0] ey;
    logic [15:0] f;
    logic [23:0] c;
    int          s;
    int          idx;
    int          mot;
    mot = 0;
`ifdef VIDEO_PATTERN_MOTION_EN
    mot = 1;
`endif
    if (px >= w) return 64'h0;
    ex = 16'((px + mot * fc) % 65536);
    ey = 16'(py);
    f  = 16'(fc % 65536);
    case (pat)
      2'd0: begin
        s = w / 8;
        idx = (s == 0) ? 7 : (int'(ex) / s);
        if (idx > 7) idx = 7;
        c = bar_color(idx);
      end
      2'd1: c = {ex[7:0], ey[7:0], f[7:0]};
      2'd2: c = (ex[5] ^ ey[5]) ? 24'hFFFFFF : 24'h000000;
      default: c = sc;
    endcase
    return {16'h0, c[23:16], 8'h0, c[15:8], 8'h0, c[7:0], 8'h0};
  endfunction

  task automatic push_frame(input int w, input int h, input logic [1:0] pat,
                            input logic [23:0] sc, input int fc);
    beat_t b;
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x += 4) begin
        b.bits = {m_pix(pat, x + 3, y, w, sc, fc), m_pix(pat, x + 2, y, w, sc, fc),
                  m_pix(pat, x + 1, y, w, sc, fc), m_pix(pat, x, y, w, sc, fc)};
        b.last = (y == h - 1) && (x + 4 >= w);
        sb.push_back(b);
      end
    end
  endtask

  // One clock: drive ready/start_frame for the coming edge, then sample outputs.
  task automatic cycle(input logic rdy, input logic sf);
    @(posedge clock);
    #1;
    vif.ready   = rdy;
    start_frame = sf;
    #1;
    obs_valid = vif.valid;
    obs_fd    = vif.frame_done;
    obs_bits  = {vif.bits_3, vif.bits_2, vif.bits_1, vif.bits_0};
  endtask

  task automatic start_cfg(input int w, input int h, input logic [1:0] pat,
                           input logic [23:0] sc, input logic rdy);
    width       = 16'(w);
    height      = 16'(h);
    pattern_sel = pat;
    solid       = sc;
    push_frame(w, h, pat, sc, exp_fc);
    cycle(rdy, 1'b1);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    reset = 1'b1;
    cycle(1'b1, 1'b0);
    width = 16'd8; height = 16'd2;
    cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b0);
    n_tests++;
    if (obs_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", obs_valid); end
    n_tests++;
    if (obs_fd !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b want 0", obs_fd); end
    n_tests++;
    if (obs_bits !== 256'h0) begin n_fail++; $display("FAIL reset_bits: got %h want 0", obs_bits); end
    reset = 1'b0;
    cycle(1'b1, 1'b0);
  endtask

  task automatic test_bars;
    beat_t e;
    start_cfg(8, 2, PAT_BARS, 24'h0, 1'b1);
    for (int c = 0; c < 4; c++) begin
      cycle(1'b1, 1'b0);
      if (c == 0) begin
        n_tests++;
        if (obs_bits[47:0] !== 48'hFF00FF00FF00)
          begin n_fail++; $display("FAIL bars_beat0: got %h want FF00FF00FF00", obs_bits[47:0]); end
      end
      n_tests++;
      if (obs_valid !== 1'b1 || sb.size() == 0) begin
        n_fail++; $display("FAIL bars_consecutive: beat %0d valid=%b want 1", c, obs_valid);
      end else begin
        e = sb.pop_front();
        if (obs_bits !== e.bits || obs_fd !== e.last) begin
          n_fail++; $display("FAIL bars_beat: got %h fd=%b want %h fd=%b", obs_bits, obs_fd, e.bits, e.last);
        end
        if (e.last) exp_fc++;
      end
    end
    cycle(1'b1, 1'b0);
    n_tests++;
    if (obs_valid !== 1'b0 || obs_fd !== 1'b0)
      begin n_fail++; $display("FAIL bars_end: valid=%b fd=%b want 0 0", obs_valid, obs_fd); end
  endtask

  task automatic test_solid;
    beat_t e;
    int    k;
    k = 0;
    start_cfg(6, 1, PAT_SOLID, 24'h123456, 1'b1);
    for (int c = 0; c < 10 && sb.size() > 0; c++) begin
      cycle(1'b1, 1'b0);
      if (obs_valid === 1'b1) begin
        e = sb.pop_front();
        n_tests++;
        if (obs_bits !== e.bits || obs_fd !== e.last) begin
          n_fail++; $display("FAIL solid_beat: got %h fd=%b want %h fd=%b", obs_bits, obs_fd, e.bits, e.last);
        end
        if (k == 0) begin
          n_tests++;
          if (obs_bits[63:0] !== 64'h0000_1200_3400_5600)
            begin n_fail++; $display("FAIL solid_pixel0: got %h want 0000120034005600", obs_bits[63:0]); end
        end
        if (k == 1) begin
          n_tests++;
          if (obs_bits[255:128] !== 128'h0)
            begin n_fail++; $display("FAIL solid_black_tail: got %h want 0", obs_bits[255:128]); end
        end
        if (e.last) exp_fc++;
        k++;
      end
    end
    n_tests++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL solid_timeout: %0d beats left want 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_stall;
    beat_t        e;
    logic [255:0] prev_bits;
    logic         prev_hold;
    logic         rdy;
    logic [3:0]   rpat;
    rpat = 4'b1001;
    prev_hold = 1'b0;
    prev_bits = '0;
    start_cfg(16, 2, PAT_GRADIENT, 24'h0, 1'b0);
    for (int c = 0; c < 48 && sb.size() > 0; c++) begin
      rdy = rpat[3 - (c % 4)];
      cycle(rdy, 1'b0);
      if (prev_hold) begin
        n_tests++;
        if (obs_valid !== 1'b1 || obs_bits !== prev_bits)
          begin n_fail++; $display("FAIL stall_hold: got %h valid=%b want %h valid=1", obs_bits, obs_valid, prev_bits); end
      end
      if (obs_valid === 1'b1 && rdy) begin
        e = sb.pop_front();
        n_tests++;
        if (obs_bits !== e.bits || obs_fd !== e.last) begin
          n_fail++; $display("FAIL stall_beat: got %h fd=%b want %h fd=%b", obs_bits, obs_fd, e.bits, e.last);
        end
        if (e.last) exp_fc++;
      end
      prev_hold = (obs_valid === 1'b1) && !rdy;
      prev_bits = obs_bits;
    end
    n_tests++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL stall_timeout: %0d beats left want 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_restart;
    beat_t e;
    int    got;
    got = 0;
    start_cfg(16, 4, PAT_CHECKER, 24'h0, 1'b1);
    for (int c = 0; c < 10 && got < 3; c++) begin
      cycle(1'b1, 1'b0);
      if (obs_valid === 1'b1) begin
        e = sb.pop_front();
        n_tests++;
        if (obs_bits !== e.bits || obs_fd !== 1'b0)
          begin n_fail++; $display("FAIL restart_old: got %h fd=%b want %h fd=0", obs_bits, obs_fd, e.bits); end
        got++;
      end
    end
    sb.delete();
    start_cfg(16, 4, PAT_GRADIENT, 24'h0, 1'b0);
    n_tests++;
    if (obs_fd !== 1'b0) begin n_fail++; $display("FAIL restart_no_done: got %b want 0", obs_fd); end
    for (int c = 0; c < 40 && sb.size() > 0; c++) begin
      cycle(1'b1, 1'b0);
      if (obs_valid === 1'b1) begin
        e = sb.pop_front();
        n_tests++;
        if (obs_bits !== e.bits || obs_fd !== e.last) begin
          n_fail++; $display("FAIL restart_beat: got %h fd=%b want %h fd=%b", obs_bits, obs_fd, e.bits, e.last);
        end
        if (e.last) exp_fc++;
      end
    end
    n_tests++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL restart_timeout: %0d beats left want 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_zero;
    logic seen;
    for (int t = 0; t < 2; t++) begin
      seen = 1'b0;
      if (t == 0) start_cfg(0, 4, PAT_BARS, 24'h0, 1'b1);
      else        start_cfg(4, 0, PAT_BARS, 24'h0, 1'b1);
      for (int c = 0; c < 5; c++) begin
        cycle(1'b1, 1'b0);
        if (obs_valid !== 1'b0 || obs_fd !== 1'b0) seen = 1'b1;
      end
      n_tests++;
      if (seen) begin n_fail++; $display("FAIL zero_dim_%0d: valid/frame_done seen=1 want 0", t); end
    end
  endtask

  task automatic test_reset_midframe;
    beat_t e;
    start_cfg(16, 2, PAT_CHECKER, 24'h0, 1'b1);
    for (int c = 0; c < 2; c++) begin
      cycle(1'b1, 1'b0);
      if (obs_valid === 1'b1) e = sb.pop_front();
    end
    reset = 1'b1;
    cycle(1'b0, 1'b0);
    n_tests++;
    if (obs_valid !== 1'b0 || obs_fd !== 1'b0 || obs_bits !== 256'h0)
      begin n_fail++; $display("FAIL reset_mid: valid=%b fd=%b bits=%h want 0", obs_valid, obs_fd, obs_bits); end
    sb.delete();
    exp_fc = 0;
    reset = 1'b0;
    cycle(1'b1, 1'b0);
    n_tests++;
    if (obs_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mid_idle: valid=%b want 0", obs_valid); end
  endtask

  task automatic test_gradient_frames;
    beat_t e;
    for (int f = 0; f < 3; f++) begin
      start_cfg(8, 1, PAT_GRADIENT, 24'h0, 1'b1);
      cycle(1'b1, 1'b0);
      n_tests++;
      if (obs_bits[15:8] !== 8'(f))
        begin n_fail++; $display("FAIL gradient_blue: frame %0d got %0d want %0d", f, obs_bits[15:8], f); end
      for (int c = 0; c < 6 && sb.size() > 0; c++) begin
        if (c > 0) cycle(1'b1, 1'b0);
        if (obs_valid === 1'b1) begin
          e = sb.pop_front();
          n_tests++;
          if (obs_bits !== e.bits || obs_fd !== e.last) begin
            n_fail++; $display("FAIL gradient_beat: got %h fd=%b want %h fd=%b", obs_bits, obs_fd, e.bits, e.last);
          end
          if (e.last) exp_fc++;
        end
      end
      n_tests++;
      if (sb.size() != 0) begin n_fail++; $display("FAIL gradient_timeout: %0d left want 0", sb.size()); sb.delete(); end
    end
  endtask

`ifdef VIDEO_PATTERN_MOTION_EN
  task automatic test_motion;
    beat_t       e;
    logic [63:0] pix32_f0;
    logic [63:0] pix0_f32;
    int          k;
    pix32_f0 = '0;
    pix0_f32 = '1;
    for (int f = 0; f <= 32; f++) begin
      k = 0;
      start_cfg(64, 1, PAT_CHECKER, 24'h0, 1'b1);
      for (int c = 0; c < 24 && sb.size() > 0; c++) begin
        cycle(1'b1, 1'b0);
        if (obs_valid === 1'b1) begin
          e = sb.pop_front();
          if (obs_bits !== e.bits || obs_fd !== e.last) begin
            n_fail++; $display("FAIL motion_beat: frame %0d got %h want %h", f, obs_bits, e.bits);
          end
          if (f == 0 && k == 8) pix32_f0 = obs_bits[63:0];
          if (f == 32 && k == 0) pix0_f32 = obs_bits[63:0];
          if (e.last) exp_fc++;
          k++;
        end
      end
      n_tests++;
      if (sb.size() != 0) begin n_fail++; $display("FAIL motion_timeout: %0d left want 0", sb.size()); sb.delete(); end
    end
    n_tests++;
    if (pix0_f32 !== pix32_f0)
      begin n_fail++; $display("FAIL motion_scroll: got %h want %h", pix0_f32, pix32_f0); end
  endtask
`endif

  initial begin
    vif.ready = 1'b0;
    obs_valid = 1'b0;
    obs_fd    = 1'b0;
    obs_bits  = '0;
    test_reset();
    test_bars();
    test_solid();
    test_stall();
    test_restart();
    test_zero();
    test_reset_midframe();
    test_gradient_frames();
`ifdef VIDEO_PATTERN_MOTION_EN
    test_motion();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
